// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, sequencer state encoding and default widths
// Purpose: common definitions for the ALU sharing controller and its arbiter.
// Ports: none (package).
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rtl/alu_share_ctrl_rr_arb2.sv - two-way round-robin arbiter with its priority pointer
// Purpose: picks which requester owns the ALU when both ask at once.
// Ports:
//   clk, rst       clock, async active-high reset (pointer back to port 0)
//   valid0/valid1  request pending on port 0 / port 1
//   advance        an acceptance happened this cycle; flip priority
//   grant          winning port index (meaningful only when any is high)
//   any            at least one request pending
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant,
  output logic any
);

  logic ptr;

  // Pointer moves only on acceptance so idle cycles never steal a turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~ptr;
    end
  end

  // A lone requester wins outright; the pointer only breaks ties.
  assign grant = (valid0 && valid1) ? ptr : valid1;
  assign any   = valid0 | valid1;

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - sequences one shared combinational ALU between two requesters
// Purpose: accepts one op at a time, registers operands onto the ALU, captures the
// result one cycle later and returns it with a zero flag to the requester that won.
// Optional feature macro: ALU_SHARE_STATS_EN adds stats_clr and per-port grant counters.
// Ports:
//   clk, rst                     clock, async active-high reset
//   reqN_valid/ready             request handshake, N = 0 (execute) / 1 (address/debug)
//   reqN_a, reqN_b, reqN_op      operands and ALU select
//   rspN_valid/ready             response handshake
//   rspN_result, rspN_zero       registered result and result==0 flag
//   alu_a, alu_b, alu_sel        registered operands/select to the ALU
//   alu_out                      ALU result
//   stats_clr                    (stats build) synchronous counter clear
//   grant0_cnt, grant1_cnt       (stats build) saturating acceptance counts
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int OPW    = OPW_DEF,
  parameter int STAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_sel,
  input  logic [WIDTH-1:0] alu_out
`ifdef ALU_SHARE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [STAT_W-1:0] grant0_cnt,
  output logic [STAT_W-1:0] grant1_cnt
`endif
);

  state_t           state, state_nxt;
  logic             grant, any_valid, accept;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [OPW-1:0]   op_q;
  logic             owner_q, zero_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .advance(accept),
    .grant  (grant),
    .any    (any_valid)
  );

  assign accept = (state == IDLE) && any_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (owner_q ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is masked by rst because IDLE is also the reset state and a pending
  // valid would otherwise show ready while reset is still asserted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (!rst && accept) begin
      req0_ready = ~grant;
      req1_ready = grant;
    end
    if (state == RESP) begin
      rsp0_valid = ~owner_q;
      rsp1_valid = owner_q;
    end
  end

  // alu_out only ever lands in a flop, keeping every output off the ALU path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= grant ? req1_a : req0_a;
        b_q     <= grant ? req1_b : req0_b;
        op_q    <= grant ? req1_op : req0_op;
        owner_q <= grant;
      end
      if (state == EXEC) begin
        result_q <= alu_out;
        zero_q   <= (alu_out == '0);
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_sel     = op_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else if (stats_clr) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (accept && !grant && (grant0_cnt != '1)) grant0_cnt <= grant0_cnt + 1'b1;
      if (accept && grant && (grant1_cnt != '1)) grant1_cnt <= grant1_cnt + 1'b1;
    end
  end
`else
  localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0]  rsp0_result, rsp1_result;
  logic          rsp0_zero, rsp1_zero;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  logic [2:0]    alu_sel;
  logic          stats_clr;
  logic [SW-1:0] g0_cnt, g1_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W), .OPW(3), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
`ifdef ALU_SHARE_STATS_EN
    .stats_clr(stats_clr), .grant0_cnt(g0_cnt), .grant1_cnt(g1_cnt),
`endif
    .alu_out(alu_out)
  );

`ifndef ALU_SHARE_STATS_EN
  assign g0_cnt = '0;
  assign g1_cnt = '0;
`endif

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  // The ALU itself: combinational, outside the controller.
  always_comb alu_out = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: at most one op in flight; a response becomes visible two
  // cycles after the cycle in which it was accepted and stays until consumed.
  bit           m_pend, m_port, m_zero, m_ptr, m_g, m_r0, m_r1, m_v0, m_v1;
  int           m_dly;
  logic [W-1:0] m_a, m_res;
  logic [2:0]   m_op;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      m_pend = 0;
      m_ptr  = 0;
    end else begin
      m_g  = (req0_valid && req1_valid) ? m_ptr : req1_valid;
      m_r0 = !m_pend && req0_valid && !m_g;
      m_r1 = !m_pend && req1_valid && m_g;
      m_v0 = m_pend && (m_dly == 0) && !m_port;
      m_v1 = m_pend && (m_dly == 0) && m_port;
      chk("req0_ready", req0_ready, m_r0);
      chk("req1_ready", req1_ready, m_r1);
      chk("rsp0_valid", rsp0_valid, m_v0);
      chk("rsp1_valid", rsp1_valid, m_v1);
      if (m_v0) begin
        chk("rsp0_result", rsp0_result, m_res);
        chk("rsp0_zero", rsp0_zero, m_zero);
      end
      if (m_v1) begin
        chk("rsp1_result", rsp1_result, m_res);
        chk("rsp1_zero", rsp1_zero, m_zero);
      end
      if (m_pend) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_sel", alu_sel, m_op);
      end
      if (m_r0 || m_r1) begin
        m_pend = 1;
        m_dly  = 1;
        m_port = m_g;
        m_a    = m_g ? req1_a : req0_a;
        m_op   = m_g ? req1_op : req0_op;
        m_res  = alu_f(m_a, m_g ? req1_b : req0_b, m_op);
        m_zero = (m_res == 0);
        m_ptr  = !m_ptr;
      end else if (m_pend) begin
        if (m_dly > 0) m_dly--;
        else if (m_port ? rsp1_ready : rsp0_ready) m_pend = 0;
      end
    end
  end

  // Logs of grants and consumed responses for the literal checks.
  bit           gq[$];
  bit           rp[$];
  logic [W-1:0] rr[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready) gq.push_back(1'b0);
      if (req1_ready) gq.push_back(1'b1);
      if (rsp0_valid && rsp0_ready) begin rp.push_back(1'b0); rr.push_back(rsp0_result); end
      if (rsp1_valid && rsp1_ready) begin rp.push_back(1'b1); rr.push_back(rsp1_result); end
    end
  end

  task automatic set_req(input bit port, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    if (port) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
  endtask

  task automatic wait_ready(input bit port, input string nm);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = port ? req1_ready : req0_ready;
    end
    chk({nm, "_accept"}, seen, 1);
  endtask

  // Issue one op on a port, check acceptance, 2-cycle latency and literal result.
  task automatic do_op(input bit port, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input logic [W-1:0] exp_res, input bit exp_zero, input string nm);
    int lat = 0;
    bit seen = 0;
    set_req(port, a, b, op);
    wait_ready(port, nm);
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      seen = port ? rsp1_valid : rsp0_valid;
    end
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_result"}, port ? rsp1_result : rsp0_result, exp_res);
    chk({nm, "_zero"}, port ? rsp1_zero : rsp0_zero, exp_zero);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    stats_clr = 1'b0;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_sel", alu_sel, 0);
    chk("reset_rsp0_result", rsp0_result, 0);
    chk("reset_rsp0_zero", rsp0_zero, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;

    // Lone requests on each port
    do_op(0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, "p0_add");
    do_op(1, 32'h20, 32'h20, ALU_SUB, 32'd0, 1'b1, "p1_sub_zero");
    do_op(1, 32'd3, 32'd9, ALU_SLT, 32'd1, 1'b0, "p1_slt");
    do_op(0, 32'd5, 32'd5, 3'b110, 32'd0, 1'b1, "p0_illegal");

    // Contention from a fresh reset: grants alternate starting at port 0
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    gq.delete(); rp.delete(); rr.delete();
    set_req(0, 32'hF0, 32'h3C, ALU_AND);
    set_req(1, 32'hF0, 32'h0F, ALU_OR);
    repeat (12) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("cont_grants", gq.size() >= 4, 1);
    chk("cont_rsps", rp.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont_grant%0d", i), (i < gq.size()) ? gq[i] : 1'bx, i % 2);
      chk($sformatf("cont_rsp_port%0d", i), (i < rp.size()) ? rp[i] : 1'bx, i % 2);
      chk($sformatf("cont_rsp_res%0d", i), (i < rr.size()) ? rr[i] : 32'hx, (i % 2) ? 32'hFF : 32'h30);
    end

    // Backpressure on port 0 while port 1 waits
    rsp0_ready = 1'b0;
    set_req(0, 32'd1, 32'd2, ALU_ADD);
    wait_ready(0, "bp_p0");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    set_req(1, 32'd10, 32'd1, ALU_SUB);
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = rsp0_valid;
      end
      chk("bp_rsp0_seen", seen, 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", rsp0_valid, 1);
      chk("bp_hold_result", rsp0_result, 32'd3);
      chk("bp_req1_blocked", req1_ready, 0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp0_valid, 1);
    chk("bp_release_req1", req1_ready, 0);
    @(negedge clk);
    chk("bp_req1_taken", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset while an op is in EXEC
    set_req(0, 32'd100, 32'd1, ALU_ADD);
    wait_ready(0, "rx_p0");
    @(posedge clk); #1;
    set_req(1, 32'd7, 32'd7, ALU_AND);
    #2;
    rst = 1'b1;
    #1;
    chk("rx_req0_ready", req0_ready, 0);
    chk("rx_req1_ready", req1_ready, 0);
    chk("rx_rsp0_valid", rsp0_valid, 0);
    chk("rx_rsp1_valid", rsp1_valid, 0);
    req0_a = 32'd40; req0_b = 32'd2;
    rp.delete(); rr.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rx_p0_priority", req0_ready, 1);
    chk("rx_p1_waits", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rx_rsp_count", rp.size(), 1);
    chk("rx_rsp_result", (rr.size() > 0) ? rr[0] : 32'hx, 32'd42);

`ifdef ALU_SHARE_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) do_op(0, i, 32'd1, ALU_ADD, i + 1, 1'b0, "st_p0");
    for (int i = 0; i < 2; i++) do_op(1, 32'd9, i, ALU_OR, 32'd9 | i, 1'b0, "st_p1");
    chk("st_cnt0", g0_cnt, 3);
    chk("st_cnt1", g1_cnt, 2);
    set_req(0, 32'd1, 32'd1, ALU_AND);
    wait_ready(0, "st_clr");
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("st_clr_cnt0", g0_cnt, 0);
    chk("st_clr_cnt1", g1_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) do_op(0, 32'd2, i, ALU_SUB, 32'd2 - i, (i == 2), "st_sat");
    chk("st_sat_cnt0", g0_cnt, 3);
    chk("st_sat_cnt1", g1_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequences the single-cycle 32-bit ALU and shares it between two requesters: port 0 (execute stage) and port 1 (address/debug unit).
- Accepts one operation at a time over a valid/ready handshake and registers the operands, which drive the ALU.
- Captures the ALU result and returns it, with a zero flag, on the winning requester's response channel.
- Sits between the requesters and the ALU instance; the ALU stays combinational and untouched.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OPW, 3, ALU select width.
- STAT_W, 16, width of the grant counters (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid / req1_valid  input  1  request pending.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
- req0_op / req1_op  input  OPW  ALU select: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- rsp0_valid / rsp1_valid  output  1  result available.
- rsp0_ready / rsp1_ready  input  1  requester consumes result.
- rsp0_result / rsp1_result  output  WIDTH  registered ALU result.
- rsp0_zero / rsp1_zero  output  1  result == 0.
- alu_a, alu_b  output  WIDTH  to ALU A/B.
- alu_sel  output  OPW  to ALU sel.
- alu_out  input  WIDTH  from ALU out.

Behaviour:
- Reset:
  - Async reset forces state IDLE and rr_ptr=0 (port 0 has priority first).
  - Operand, op, owner and result registers clear to 0.
  - All ready/valid outputs are 0 while rst is high.
  - A reset mid-operation discards the in-flight op; no response is produced.
- FSM states and transitions:
  - IDLE: grant is combinational.
    - Only one valid: that port wins.
    - Both valid: the port equal to rr_ptr wins.
    - reqN_ready = (state==IDLE) && grant==N. Only one ready can be high at a time.
    - On acceptance (valid&&ready): latch a, b, op and owner=N, toggle rr_ptr to the other port, go to EXEC.
  - EXEC: alu_a/alu_b/alu_sel come from the registers. At the clock edge, capture alu_out into result and set zero = (alu_out==0), computed here for every op rather than taken from the ALU. Go to RESP.
  - RESP: rsp{owner}_valid=1. When rsp{owner}_ready=1, go to IDLE.
- Response outputs:
  - rspN_result/zero are driven from the shared result register and are meaningful only while rspN_valid.
  - rspN_valid for the non-owner is 0.
  - Result, zero and valid hold stable until accepted.
- Latency and throughput:
  - Acceptance at edge T, ALU evaluated during T+1, rsp_valid visible after edge T+2.
  - Minimum 3 cycles per op; no new request is accepted until RESP completes.
- Requester rules:
  - A requester must hold valid and payload stable until ready.
  - Dropping valid before ready is legal; the request is simply not taken.
- rr_ptr toggles only on acceptance, never on idle cycles.
  - Lone-port requests also toggle it. With continuous demand, grants strictly alternate.
- Illegal ops (100, 110, 111) are passed through unchanged. The ALU yields 0, so the response is result 0, zero=1.
- alu_a/alu_b/alu_sel always reflect the registers, including outside EXEC.
- All outputs are registered or derived from state; no combinational path from alu_out to any output.

Optional Feature:
- Macro ALU_SHARE_STATS_EN.
- Defined:
  - Adds outputs grant0_cnt and grant1_cnt [STAT_W-1:0].
  - Each increments on its port's acceptance, saturates at all-ones, and clears on rst.
  - Adds input stats_clr (1 bit, synchronous clear; clear wins over a same-cycle increment).
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - State encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - WIDTH default.
- One natural sub-module, rr_arb2:
  - Combinational 2-way round-robin grant from valids and rr_ptr.
  - Includes the rr_ptr flop, with an advance input driven by acceptance.

Test Plan:
- Reset then req0 alone: a=5, b=7, op=000, rsp0_ready=1 -> req0_ready at cycle 0, rsp0_valid two cycles later, result=12, zero=0, rsp1_valid never high.
- Sub to zero on port 1: a=0x20, b=0x20, op=001 -> rsp1_result=0, rsp1_zero=1. Then a=3, b=9, op=101 -> result=1, zero=0.
- Contention: both valid every cycle, rsp ready=1 -> grants alternate 0,1,0,1 starting with port 0 after reset. Each response goes to the correct owner with its own operands (e.g. 0xF0 & 0x3C = 0x30 on port 0, 0xF0 | 0x0F = 0xFF on port 1).
- Backpressure: rsp0_ready held 0 for 5 cycles while req1 is valid:
  - rsp0_valid/result stay stable.
  - req1_ready stays 0.
  - After rsp0_ready rises, req1 is accepted on the following IDLE cycle.
- Reset in EXEC with req0 in flight: assert rst asynchronously -> all valid/ready drop immediately, no response is produced, and after release port 0 has priority.
- With ALU_SHARE_STATS_EN: 3 grants port 0, 2 grants port 1 -> counts 3/2. Pulse stats_clr in the same cycle as a grant -> both counts 0. STAT_W=2 with 5 grants -> saturates at 3.
